// File: rtl/rng_stream_checker.sv
// rng_stream_checker
//   Receive-side checker for the 128-bit xorshift RNG stream
//   next(s) = s ^ (s<<13) ^ (s>>17) ^ (s<<5), logical shifts truncated to 128 bits.
//   The checker self-synchronises to the stream (HUNT -> SYNC -> LOCKED).
//   It flags words that break the sequence and counts them.
//   It drops lock after LOSS_COUNT consecutive misses (LOCKED -> LOST -> HUNT).
//   Optional build macro: RNG_CHECK_ZERO_DETECT_EN. When it is defined, an
//   all-zero word is treated as invalid stream content. Such a word never seeds
//   the prediction and always misses while locked.
`timescale 1ns/1ps

module rng_stream_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic         clear_counts,
  output logic         locked,
  output logic         mismatch,
  output logic [15:0]  err_count,
  output logic [31:0]  word_count,
  output logic [1:0]   state
);

  localparam int unsigned DATA_W = 128;

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_COUNT);

`ifdef RNG_CHECK_ZERO_DETECT_EN
  localparam bit ZERO_DET = 1'b1;
`else
  localparam bit ZERO_DET = 1'b0;
`endif

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_t;

  // One xorshift step; purely combinational so a word can be checked every cycle.
  function automatic logic [DATA_W-1:0] xs_next(input logic [DATA_W-1:0] s);
    return s ^ (s << 13) ^ (s >> 17) ^ (s << 5);
  endfunction

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   expected_q, expected_d;
  logic [7:0]          run_q, run_d;
  logic                locked_q, locked_d;
  logic                mismatch_q, mismatch_d;
  logic [15:0]         err_q, err_d;
  logic [31:0]         wc_q, wc_d;

  logic                data_zero;
  logic                hit;
  logic [7:0]          run_inc;
  logic [DATA_W-1:0]   pred_in;
  logic [DATA_W-1:0]   pred_free;

  // Word classification and the two candidate predictions (reseed vs. free-run).
  always_comb begin
    data_zero = ZERO_DET && (in_data == '0);
    hit       = (in_data == expected_q) && !data_zero;
    run_inc   = run_q + 8'd1;
    pred_in   = xs_next(in_data);
    pred_free = xs_next(expected_q);
  end

  // State and all registered outputs; everything returns to zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      expected_q <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      wc_q       <= wc_d;
    end
  end

  // Next-state logic; only valid words move the FSM, except LOST which always exits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (in_valid && !data_zero) state_d = SYNC;
      end
      SYNC: begin
        if (in_valid) begin
          if (data_zero)                     state_d = HUNT;
          else if (hit && run_inc == LOCK_N) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid && !hit && run_inc == LOSS_N) state_d = LOST;
      end
      LOST: begin
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Datapath and output next values: prediction, run counter, pulse and counters.
  always_comb begin
    expected_d = expected_q;
    run_d      = run_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    wc_d       = wc_q;
    unique case (state_q)
      HUNT: begin
        if (in_valid && !data_zero) begin
          expected_d = pred_in;
          run_d      = '0;
        end
      end
      SYNC: begin
        if (in_valid) begin
          if (data_zero) begin
            run_d = '0;
          end else if (hit) begin
            expected_d = pred_in;
            run_d      = (run_inc == LOCK_N) ? 8'd0 : run_inc;
          end else begin
            // Any miss while synchronising simply reseeds from the new word.
            expected_d = pred_in;
            run_d      = '0;
          end
        end
      end
      LOCKED: begin
        if (in_valid) begin
          wc_d = wc_q + 32'd1;
          if (hit) begin
            expected_d = pred_in;
            run_d      = '0;
          end else begin
            // Free-run the prediction so a single corrupted word does not derail it.
            mismatch_d = 1'b1;
            err_d      = sat_inc16(err_q);
            expected_d = pred_free;
            run_d      = run_inc;
          end
        end
      end
      LOST: begin
        run_d = '0;
      end
      default: begin
        run_d = '0;
      end
    endcase
    // A clear beats a same-cycle increment.
    if (clear_counts) begin
      err_d = '0;
      wc_d  = '0;
    end
  end

  // Lock flag is registered alongside the state it mirrors.
  always_comb begin
    locked_d = (state_d == LOCKED);
  end

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign word_count = wc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rng_stream_checker.sv
// Directed testbench for rng_stream_checker.
// Instance a uses the default LOCK/LOSS counts. Instance b uses LOSS_COUNT=255
// so that a long run of misses never drops the lock.
`timescale 1ns/1ps

module tb_rng_stream_checker;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         clear_counts = 1'b0;

  logic         locked_a, mismatch_a, locked_b, mismatch_b;
  logic [15:0]  err_a, err_b;
  logic [31:0]  wc_a, wc_b;
  logic [1:0]   st_a, st_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] s;

  always #5 clk = ~clk;

  rng_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_counts(clear_counts), .locked(locked_a), .mismatch(mismatch_a),
    .err_count(err_a), .word_count(wc_a), .state(st_a)
  );

  rng_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(255)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_counts(clear_counts), .locked(locked_b), .mismatch(mismatch_b),
    .err_count(err_b), .word_count(wc_b), .state(st_b)
  );

  function automatic logic [127:0] nxt(input logic [127:0] x);
    return x ^ (x << 13) ^ (x >> 17) ^ (x << 5);
  endfunction

  task automatic drive(input logic v, input logic [127:0] d, input logic clr);
    @(negedge clk);
    in_valid = v; in_data = d; clear_counts = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_counts = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_cmp++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st_a); end
    n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked_a); end
    n_cmp++; if (mismatch_a !== 1'b0) begin n_bad++; $display("FAIL reset_mismatch: got %b want 0", mismatch_a); end
    n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_a); end
    n_cmp++; if (wc_a !== 32'd0) begin n_bad++; $display("FAIL reset_wc: got %0d want 0", wc_a); end
  endtask

  task automatic test_clean_lock();
    logic [127:0] w [0:2];
    w[0] = 128'h1; w[1] = 128'h2021; w[2] = 128'h0400_0401;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w[i], 1'b0);
      if (i == 0) begin
        n_cmp++; if (st_a !== 2'd1) begin n_bad++; $display("FAIL lock_sync_state: got %0d want 1", st_a); end
      end
      n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL lock_early_%0d: got %b want 0", i, locked_a); end
    end
    s = nxt(w[2]);
    drive(1'b1, s, 1'b0); s = nxt(s);
    n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL lock_early_4: got %b want 0", locked_a); end
    drive(1'b1, s, 1'b0); s = nxt(s);
    n_cmp++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL lock_rise: got %b want 1", locked_a); end
    n_cmp++; if (st_a !== 2'd2) begin n_bad++; $display("FAIL lock_state: got %0d want 2", st_a); end
    n_cmp++; if (wc_a !== 32'd0) begin n_bad++; $display("FAIL lock_wc0: got %0d want 0", wc_a); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s, 1'b0); s = nxt(s);
      n_cmp++; if (mismatch_a !== 1'b0) begin n_bad++; $display("FAIL clean_mismatch_%0d: got %b want 0", i, mismatch_a); end
      n_cmp++; if (wc_a !== 32'(i + 1)) begin n_bad++; $display("FAIL clean_wc_%0d: got %0d want %0d", i, wc_a, i + 1); end
    end
  endtask

  task automatic test_single_corruption();
    drive(1'b1, s ^ 128'h1, 1'b0); s = nxt(s);
    n_cmp++; if (mismatch_a !== 1'b1) begin n_bad++; $display("FAIL corrupt_pulse: got %b want 1", mismatch_a); end
    n_cmp++; if (err_a !== 16'd1) begin n_bad++; $display("FAIL corrupt_err: got %0d want 1", err_a); end
    n_cmp++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL corrupt_locked: got %b want 1", locked_a); end
    drive(1'b1, s, 1'b0); s = nxt(s);
    n_cmp++; if (mismatch_a !== 1'b0) begin n_bad++; $display("FAIL corrupt_resume: got %b want 0", mismatch_a); end
    n_cmp++; if (err_a !== 16'd1) begin n_bad++; $display("FAIL corrupt_err_hold: got %0d want 1", err_a); end
    n_cmp++; if (wc_a !== 32'd5) begin n_bad++; $display("FAIL corrupt_wc: got %0d want 5", wc_a); end
  endtask

  task automatic test_loss();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, s ^ 128'hFF00, 1'b0); s = nxt(s);
      n_cmp++; if (err_a !== 16'(1 + i)) begin n_bad++; $display("FAIL loss_err_%0d: got %0d want %0d", i, err_a, 1 + i); end
      n_cmp++; if (mismatch_a !== 1'b1) begin n_bad++; $display("FAIL loss_pulse_%0d: got %b want 1", i, mismatch_a); end
      if (i < 3) begin
        n_cmp++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL loss_held_%0d: got %b want 1", i, locked_a); end
      end
    end
    n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL loss_fall: got %b want 0", locked_a); end
    n_cmp++; if (st_a !== 2'd3) begin n_bad++; $display("FAIL loss_lost: got %0d want 3", st_a); end
    n_cmp++; if (wc_a !== 32'd8) begin n_bad++; $display("FAIL loss_wc: got %0d want 8", wc_a); end
    // A word presented during LOST is ignored.
    drive(1'b1, s, 1'b0);
    n_cmp++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL loss_hunt: got %0d want 0", st_a); end
    n_cmp++; if (mismatch_a !== 1'b0) begin n_bad++; $display("FAIL loss_nopulse: got %b want 0", mismatch_a); end
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, s, 1'b0); s = nxt(s);
      if (i == 4) begin
        n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0", locked_a); end
      end
    end
    n_cmp++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL relock: got %b want 1", locked_a); end
  endtask

  task automatic test_gapped_clear();
    do_reset();
    s = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, s, 1'b0); s = nxt(s);
      if (i == 1) begin
        n_cmp++; if (st_a !== 2'd1) begin n_bad++; $display("FAIL gap_sync: got %0d want 1", st_a); end
      end
      if (i == 4) begin
        n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL gap_early: got %b want 0", locked_a); end
      end
      drive(1'b0, ~s, 1'b0);
    end
    n_cmp++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL gap_lock: got %b want 1", locked_a); end
    n_cmp++; if (mismatch_a !== 1'b0 || wc_a !== 32'd0) begin n_bad++; $display("FAIL gap_hold: got mm=%b wc=%0d want mm=0 wc=0", mismatch_a, wc_a); end
    drive(1'b1, s ^ 128'h1, 1'b1); s = nxt(s);
    n_cmp++; if (mismatch_a !== 1'b1) begin n_bad++; $display("FAIL clear_pulse: got %b want 1", mismatch_a); end
    n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL clear_err: got %0d want 0", err_a); end
    n_cmp++; if (wc_a !== 32'd0) begin n_bad++; $display("FAIL clear_wc: got %0d want 0", wc_a); end
    drive(1'b1, s, 1'b0); s = nxt(s);
    n_cmp++; if (mismatch_a !== 1'b0) begin n_bad++; $display("FAIL clear_resume: got %b want 0", mismatch_a); end
    n_cmp++; if (wc_a !== 32'd1) begin n_bad++; $display("FAIL clear_wc_inc: got %0d want 1", wc_a); end
  endtask

  task automatic test_zero_stream();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 128'h0, 1'b0);
`ifndef RNG_CHECK_ZERO_DETECT_EN
      if (i == 4) begin
        n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL zero_early: got %b want 0", locked_a); end
      end
      if (i == 5) begin
        n_cmp++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL zero_lock: got %b want 1", locked_a); end
      end
`endif
    end
`ifdef RNG_CHECK_ZERO_DETECT_EN
    n_cmp++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL zero_locked: got %b want 0", locked_a); end
    n_cmp++; if (st_a !== 2'd0) begin n_bad++; $display("FAIL zero_state: got %0d want 0", st_a); end
`else
    n_cmp++; if (wc_a !== 32'd5) begin n_bad++; $display("FAIL zero_wc: got %0d want 5", wc_a); end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    s = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s, 1'b0); s = nxt(s);
    end
    n_cmp++; if (locked_b !== 1'b1) begin n_bad++; $display("FAIL sat_lock: got %b want 1", locked_b); end
    for (int blk = 0; blk < 656; blk++) begin
      for (int k = 0; k < 100; k++) begin
        drive(1'b1, s ^ 128'h1, 1'b0); s = nxt(s);
      end
      drive(1'b1, s, 1'b0); s = nxt(s);
      if (blk == 0) begin
        n_cmp++; if (err_b !== 16'd100) begin n_bad++; $display("FAIL sat_err_100: got %0d want 100", err_b); end
      end
    end
    n_cmp++; if (err_b !== 16'hFFFF) begin n_bad++; $display("FAIL sat_err: got %h want ffff", err_b); end
    n_cmp++; if (locked_b !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %b want 1", locked_b); end
    // Reset asserted mid-stream, between clock edges, with a valid word present.
    @(negedge clk);
    in_valid = 1'b1; in_data = s;
    reset = 1'b1;
    #2;
    n_cmp++; if (st_b !== 2'd0 || locked_b !== 1'b0 || mismatch_b !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl_b: got st=%0d lk=%b mm=%b want 0", st_b, locked_b, mismatch_b); end
    n_cmp++; if (err_b !== 16'd0 || wc_b !== 32'd0) begin n_bad++; $display("FAIL rst_cnt_b: got err=%0d wc=%0d want 0", err_b, wc_b); end
    n_cmp++; if (st_a !== 2'd0 || locked_a !== 1'b0 || err_a !== 16'd0 || wc_a !== 32'd0) begin n_bad++; $display("FAIL rst_all_a: got st=%0d lk=%b err=%0d wc=%0d want 0", st_a, locked_a, err_a, wc_a); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, s, 1'b0); s = nxt(s);
    n_cmp++; if (st_b !== 2'd1 || locked_b !== 1'b0) begin n_bad++; $display("FAIL rst_relock: got st=%0d lk=%b want st=1 lk=0", st_b, locked_b); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_single_corruption();
    test_loss();
    test_gapped_clear();
    test_zero_stream();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
